// File: rtl/cmd_fifo_arbiter.sv
// Command front-end: channel arbitration plus level-scaled gravity,
// buffered in a show-ahead FIFO drained through valid/ready.
module cmd_fifo_arbiter #(
  parameter int N_CH      = 4,
  parameter int CMD_W     = 4,
  parameter int DEPTH     = 8,
  parameter int GRAV_TICK = 100_000_000,
  parameter int MIN_TICK  = 1_000_000,
  parameter int LVL_W     = 4,
  parameter int GRAV_CMD  = 2,
  parameter int OVF_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         req_valid,
  input  logic [N_CH*CMD_W-1:0]   req_cmd,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [LVL_W-1:0]        level,
  output logic                    out_valid,
  output logic [CMD_W-1:0]        out_cmd,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(GRAV_TICK + 1);
  localparam logic [PW-1:0] GT = PW'(GRAV_TICK);
  localparam logic [PW-1:0] MT = PW'(MIN_TICK);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CMD_W-1:0] GCMD = CMD_W'(GRAV_CMD);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic [PW-1:0]    per_q, per_d;
  logic [PW-1:0]    gcnt_q, gcnt_d;
  logic             pend_q, pend_d;

  logic             win_any;
  logic             lost;
  logic [CMD_W-1:0] win_cmd;
  logic             grav_req;
  logic             push_req;
  logic [CMD_W-1:0] push_cmd;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             ovw;
  logic             drop_full;
  logic             grav_done;
  logic             drop_evt;
  logic             tick;
  logic [PW-1:0]    shifted;

  // Ascending scan so the highest-index hit overwrites the winner.
  always_comb begin
    win_any = 1'b0;
    lost    = 1'b0;
    win_cmd = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (req_valid[i] &&
          (req_cmd[i*CMD_W +: CMD_W] != '0)) begin
        if (win_any) lost = 1'b1;
        win_any = 1'b1;
        win_cmd = req_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

  assign grav_req = pend_q & enable;
  assign push_req = win_any | grav_req;
  assign push_cmd = win_any ? win_cmd : GCMD;
  assign full     = (cnt_q == FULL_CNT);
  assign pop      = out_valid & out_ready;

  always_comb begin
    wr_en     = 1'b0;
    ovw       = 1'b0;
    drop_full = 1'b0;
    if (push_req) begin
      if (!full || pop) begin
        wr_en = 1'b1;
      end else if (OVF_MODE != 0) begin
        wr_en = 1'b1;
        ovw   = 1'b1;
      end else begin
        drop_full = win_any;
      end
    end
  end

  assign grav_done = grav_req & ~win_any & wr_en;
  assign drop_evt  = lost | drop_full | ovw;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (drop_evt && !flush && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + AW'(wr_en);
      rd_d  = rd_q + AW'(pop | ovw);
      cnt_d = cnt_q + CW'(wr_en & ~ovw) - CW'(pop);
    end
  end

  assign shifted = GT >> level;
  assign per_d   = (shifted < MT) ? MT : shifted;
  assign tick    = enable && (gcnt_q >= per_q - PW'(1));

  always_comb begin
    gcnt_d = '0;
    pend_d = 1'b0;
    if (enable && !flush) begin
      gcnt_d = tick ? '0 : gcnt_q + PW'(1);
      pend_d = (pend_q & ~grav_done) | tick;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      per_q  <= GT;
      gcnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      per_q  <= per_d;
      gcnt_q <= gcnt_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush)
      mem[wr_q] <= push_cmd;
  end

  assign out_valid = (cnt_q != '0);
  assign out_cmd   = out_valid ? mem[rd_q] : '0;
  assign count     = cnt_q;
  assign drop_cnt  = drop_q;

endmodule
